// File: rtl/keccak_sponge.sv
// Keccak sponge controller: absorb, pad and squeeze around an external f1600.
// State words are MSB-first; message byte 0 of a word sits in its top byte.
module keccak_sponge #(
  parameter int         RATE_WORDS = 21,
  parameter logic [7:0] DSBYTE     = 8'h1F
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [15:0]   i_out_words,
  input  logic [63:0]   i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_last,
  input  logic [3:0]    i_bytes,
  output logic [1599:0] o_perm_state,
  output logic          o_perm_valid,
  input  logic [1599:0] i_perm_state,
  input  logic          i_perm_valid,
  output logic [63:0]   o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic          o_busy
);

  localparam logic [4:0] LAST_W = 5'(RATE_WORDS - 1);
  localparam logic [7:0] RATE_B = 8'(8 * RATE_WORDS);
  localparam int         LAST_B = 8 * RATE_WORDS - 1;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PERM,
    PAD,
    SQUEEZE
  } state_e;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [1599:0] st_q, st_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   rem_q, rem_d;
  logic [7:0]    pad_q, pad_d;
  logic          first_q, first_d;

  logic [3:0]    nb;
  logic [63:0]   din;
  logic [63:0]   word;
  logic [7:0]    p;

  // Mask the final word to its valid bytes and locate the pad byte.
  always_comb begin
    nb  = (i_bytes > 4'd8) ? 4'd8 : i_bytes;
    din = i_data;
    if (i_last) begin
      din = i_data & ~({64{1'b1}} >> {nb, 3'b000});
    end
    p = {idx_q, 3'b000} + {4'd0, nb};
  end

  // Select the state word currently addressed by the index.
  always_comb begin
    word = '0;
    for (int w = 0; w < RATE_WORDS; w++) begin
      if (idx_q == 5'(w)) begin
        word = st_q[1599-64*w -: 64];
      end
    end
  end

  // Next-state and datapath update for the sponge FSM.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    st_d    = st_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    pad_d   = pad_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          st_d    = '0;
          idx_d   = '0;
          rem_d   = (i_out_words == 16'd0) ? 16'd1 : i_out_words;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (i_valid) begin
          for (int w = 0; w < RATE_WORDS; w++) begin
            if (idx_q == 5'(w)) begin
              st_d[1599-64*w -: 64] = st_q[1599-64*w -: 64] ^ din;
            end
          end
          idx_d = idx_q + 5'd1;
          if (i_last) begin
            if (p == RATE_B) begin
              state_d = PERM;
              ret_d   = PAD;
              pad_d   = '0;
            end else begin
              state_d = PAD;
              pad_d   = p;
            end
          end else if (idx_q == LAST_W) begin
            state_d = PERM;
            ret_d   = ABSORB;
          end
        end
      end
      PAD: begin
        for (int b = 0; b < 8*RATE_WORDS; b++) begin
          if (pad_q == 8'(b)) begin
            st_d[1599-8*b -: 8] = st_q[1599-8*b -: 8] ^ DSBYTE;
          end
        end
        st_d[1599-8*LAST_B -: 8] = st_d[1599-8*LAST_B -: 8] ^ 8'h80;
        state_d = PERM;
        ret_d   = SQUEEZE;
      end
      PERM: begin
        if (i_perm_valid) begin
          st_d    = i_perm_state;
          idx_d   = '0;
          state_d = ret_q;
        end
      end
      SQUEEZE: begin
        if (i_ready) begin
          rem_d = rem_q - 16'd1;
          idx_d = idx_q + 5'd1;
          if (rem_q == 16'd1) begin
            state_d = IDLE;
          end else if (idx_q == LAST_W) begin
            state_d = PERM;
            ret_d   = SQUEEZE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    first_d = (state_d == PERM) && (state_q != PERM);
  end

  // State register with synchronous reset that aborts any operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      st_q    <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      pad_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      st_q    <= st_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      pad_q   <= pad_d;
      first_q <= first_d;
    end
  end

  assign o_ready      = (state_q == ABSORB);
  assign o_valid      = (state_q == SQUEEZE);
  assign o_last       = o_valid && (rem_q == 16'd1);
  assign o_data       = o_valid ? word : '0;
  assign o_busy       = (state_q != IDLE);
  assign o_perm_valid = first_q;
  assign o_perm_state = st_q;

endmodule
